riscv_muldiv: RTL and testbench
===============================

# riscv_muldiv

Iterative RV32M/RV64M multiply-divide unit executing the eight M-extension `OpcodeOp` operations (funct7 `0000001`) for the core's execute stage. Operands arrive over a valid/ready handshake, and the result leaves over a second valid/ready handshake with a destination-register tag. Width is parametrised by XLEN. The unit holds one operation at a time. Multiply can run either as a single-cycle combinational array or as an iterative shift-add.

## Interface
- `XLEN`, default `riscv_pkg::XLEN` (32): operand and result width; must be 32 or 64.
- `FAST_MUL`, default 0: 1 computes the product in one cycle; 0 uses an iterative shift-add over XLEN cycles.
- `clk_i` in 1: clock. One clock domain.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `valid_i` in 1: request valid.
- `ready_o` out 1: unit can accept a request.
- `op_i` in 3: funct3 of the M-extension instruction.
- `rs1_i` in XLEN: operand a (dividend / multiplicand).
- `rs2_i` in XLEN: operand b (divisor / multiplier).
- `rd_i` in 5: destination tag, passed through unchanged.
- `flush_i` in 1: abort any held or in-flight operation.
- `valid_o` out 1: result valid.
- `ready_i` in 1: consumer accepts the result.
- `result_o` out XLEN: result.
- `rd_o` out 5: tag of the result.
- `busy_o` out 1: state is not IDLE.

## Operation
- **States and transitions:**
  - IDLE: `ready_o`=1. Accept on `valid_i & ready_o`.
  - MUL: iterate.
  - DIV: iterate.
  - DONE: `valid_o`=1. Leave on `valid_o & ready_i`, going to IDLE.
- **On accept:**
  - Latch `op_i` and `rd_i`.
  - Record the result sign.
  - Load operand magnitudes. Signedness by op:
    - MUL, MULH, DIV, REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - MULHU, DIVU, REMU: both operands unsigned.
  - Clear the 0..XLEN-1 iteration counter.
  - Pick the next state:
    - Special case or `FAST_MUL`=1 multiply: DONE.
    - Otherwise: MUL or DIV.
- **MUL:** one shift-add step per cycle into a 2·XLEN-bit accumulator. After XLEN steps, conditionally negate the product, then select the result:
  - MUL: low half.
  - MULH, MULHSU, MULHU: high half.
- **DIV:** one restoring step per cycle, producing one quotient bit and a partial remainder. After XLEN steps, apply signs:
  - Quotient negated when the operand signs differ.
  - Remainder takes the dividend's sign.
- **Special cases**, resolved at accept and bypassing iteration:
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (rs1 = −2^(XLEN−1), rs2 = −1): DIV returns rs1; REM returns 0.
- **`flush_i`:**
  - Moves any state to IDLE at the next edge.
  - Has priority over both accept and result handshake in the same cycle.
  - Flushed results are never presented.
- `result_o` and `rd_o` are registered. They are stable throughout DONE.

## Timing
- **Reset** (asynchronous, immediate):
  - State = IDLE.
  - `valid_o`=0, `busy_o`=0.
  - `result_o`=0, `rd_o`=0.
  - Counter = 0.
  - `ready_o`=1, since it is decoded from IDLE.
- **Latency**, counted from the accept edge to the first cycle `valid_o`=1:
  - Iterative MUL and DIV: XLEN cycles.
  - Special-case divide and `FAST_MUL` multiply: 1 cycle.
- **Handshake rules:**
  - `ready_o`=0 in MUL, DIV and DONE. There is no accept in the same cycle as the result handshake.
  - The next accept is possible the cycle after returning to IDLE.
  - `valid_o` is held until `ready_i`. Backpressure is unbounded.
- **Reset mid-operation:** all state is discarded. No result is ever emitted for that operation.

## Structure
- **`riscv_pkg` additions:**
  - `F7_MULDIV` = 7'b0000001.
  - funct3 constants: F3_MUL=000, F3_MULH=001, F3_MULHSU=010, F3_MULHU=011, F3_DIV=100, F3_DIVU=101, F3_REM=110, F3_REMU=111.
  - typedef enum `muldiv_state_e` {IDLE, MUL, DIV, DONE}.
- **Module structure:** single module, one FSM, with the datapath shared between both iterations. No sub-module.

## Test plan
All values are for XLEN=32 and `FAST_MUL`=0 unless stated.
- **Multiply results and latency:**
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, with `valid_o` exactly 32 cycles after accept.
  - With `FAST_MUL`=1, the same multiply completes in 1 cycle.
- **High-half products:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Division sign rules:**
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - `rd_o` equals the accepted `rd_i` in every case.
- **Special cases:** each result appears 1 cycle after accept.
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- **Backpressure:**
  - Hold `ready_i`=0 for 10 cycles in DONE: `result_o` and `rd_o` stay stable, and `ready_o` stays 0.
  - On handshake, `ready_o`=1 the next cycle and a new accept succeeds.
- **Flush and reset mid-operation:**
  - Assert `flush_i` in cycle 5 of DIV: IDLE at the next edge, with no `valid_o` ever raised.
  - Assert `rstn_i` low mid-MUL: all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Core-wide RISC-V definitions shared by the execute-stage units.
// Contents: default XLEN, the M-extension funct7/funct3 encodings and the
// multiply-divide unit FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // M-extension OpcodeOp encodings
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_e;

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply-divide unit (one operation in flight).
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   valid_i / ready_o    request handshake carrying op_i (funct3), rs1_i, rs2_i, rd_i
//   flush_i              discard any held or in-flight operation
//   valid_o / ready_i    result handshake carrying result_o and rd_o
//   busy_o               unit is not idle
//
// Multiply is a right-shifting shift-add on operand magnitudes, divide is a
// restoring divider on magnitudes; both share one 2*XLEN accumulator and the
// signs are applied when the last step is written into result_q.
module riscv_muldiv #(
  parameter int unsigned XLEN     = riscv_pkg::XLEN,
  parameter bit          FAST_MUL = 1'b0
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  import riscv_pkg::*;

  localparam int unsigned     CntW    = $clog2(XLEN);
  // The first step runs on the accept edge, so the counter only covers the rest.
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 2);
  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e      state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         rd_q, rd_d;
  logic [XLEN-1:0]    opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]  acc_q, acc_d;       // mul: {partial, multiplier}; div: {rem, quotient}
  logic               neg_q, neg_d;       // product / quotient negative
  logic               rem_neg_q, rem_neg_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]    result_q, result_d;

  // Request decode
  logic              is_div, a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    is_div   = op_i[2];
    a_signed = op_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed = op_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    sign_a   = a_signed & rs1_i[XLEN-1];
    sign_b   = b_signed & rs2_i[XLEN-1];
    mag_a    = sign_a ? -rs1_i : rs1_i;
    mag_b    = sign_b ? -rs2_i : rs2_i;
    div_zero = is_div & (rs2_i == '0);
    div_ovf  = (op_i inside {F3_DIV, F3_REM}) & (rs1_i == MinInt) & (rs2_i == '1);
    special  = div_zero | div_ovf;
    // op_i[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) begin
      special_res = op_i[1] ? rs1_i : '1;
    end else begin
      special_res = op_i[1] ? '0 : rs1_i;
    end
  end

  // One shared iteration step; in IDLE it is fed the freshly loaded operands.
  logic              step_is_div;
  logic [XLEN-1:0]   step_opnd;
  logic [2*XLEN-1:0] step_acc, step_out;
  logic [XLEN:0]     mul_sum, div_diff;

  always_comb begin
    if (state_q == IDLE) begin
      step_is_div = is_div;
      step_opnd   = is_div ? mag_b : mag_a;
      step_acc    = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
    end else begin
      step_is_div = (state_q == DIV);
      step_opnd   = opnd_q;
      step_acc    = acc_q;
    end
    mul_sum  = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, step_opnd} : '0);
    // Shifted partial remainder needs XLEN+1 bits before the trial subtract.
    div_diff = step_acc[2*XLEN-1:XLEN-1] - {1'b0, step_opnd};
    if (step_is_div) begin
      if (div_diff[XLEN]) begin
        step_out = {step_acc[2*XLEN-2:0], 1'b0};
      end else begin
        step_out = {div_diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      step_out = {mul_sum, step_acc[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection after the final step
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_mag, rem_mag, iter_res;

  always_comb begin
    prod    = neg_q ? -step_out : step_out;
    quo_mag = step_out[XLEN-1:0];
    rem_mag = step_out[2*XLEN-1:XLEN];
    if (state_q == DIV) begin
      if (op_q[1]) begin
        iter_res = rem_neg_q ? -rem_mag : rem_mag;
      end else begin
        iter_res = neg_q ? -quo_mag : quo_mag;
      end
    end else begin
      iter_res = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  // Single-cycle array product, only selected when FAST_MUL is set
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_mag  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    fast_prod = (sign_a ^ sign_b) ? -fast_mag : fast_mag;
    fast_res  = (op_i == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          op_d      = op_i;
          rd_d      = rd_i;
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          cnt_d     = '0;
          if (special) begin
            result_d = special_res;
            state_d  = DONE;
          end else if (FAST_MUL && !is_div) begin
            result_d = fast_res;
            state_d  = DONE;
          end else begin
            opnd_d  = step_opnd;
            acc_d   = step_out;
            state_d = is_div ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        if (cnt_q == LastCnt) begin
          result_d = iter_res;
          state_d  = DONE;
        end else begin
          acc_d = step_out;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides both handshakes.
    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Self-checking bench for riscv_muldiv (XLEN=32): iterative instance checked
// every cycle against a 64-bit arithmetic model, plus a FAST_MUL instance.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        busy_o;

  logic        f_valid_i = 1'b0;
  logic        f_ready_o;
  logic        f_flush_i = 1'b0;
  logic        f_valid_o;
  logic        f_ready_i = 1'b1;
  logic [31:0] f_result_o;
  logic [4:0]  f_rd_o;
  logic        f_busy_o;

  riscv_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .rd_o(rd_o), .busy_o(busy_o)
  );

  riscv_muldiv #(.XLEN(32), .FAST_MUL(1'b1)) dut_fast (
    .clk_i(clk), .rstn_i(rstn_i), .valid_i(f_valid_i), .ready_o(f_ready_o), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(f_flush_i), .valid_o(f_valid_o),
    .ready_i(f_ready_i), .result_o(f_result_o), .rd_o(f_rd_o), .busy_o(f_busy_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   ncyc = 0;
  bit   rdy_rand = 1'b0;
  bit   rdy_val = 1'b1;

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          p;
    longint unsigned up;
    bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare process: runs on every falling edge.
  task automatic monitor();
    bit   prev_v = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rstn_i) begin
        expq.delete();
        prev_v = 1'b0;
      end else begin
        if (valid_o) begin
          if (expq.size() == 0) begin
            chk("spurious_valid", 64'(valid_o), 64'd0);
          end else begin
            e = expq[0];
            chk("result", 64'(result_o), 64'(e.res));
            chk("rd", 64'(rd_o), 64'(e.rd));
            chk("ready_in_done", 64'(ready_o), 64'd0);
            if (!prev_v) chk("latency", 64'(ncyc - e.acc), 64'(e.lat));
          end
        end
        prev_v = valid_o;
        if (flush_i) begin
          expq.delete();
        end else begin
          if (valid_o && ready_i && expq.size() > 0) void'(expq.pop_front());
          if (valid_i && ready_o) begin
            e.res = model(op_i, rs1_i, rs2_i);
            e.rd  = rd_i;
            e.acc = ncyc;
            e.lat = model_lat(op_i, rs1_i, rs2_i);
            expq.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int n = 0;
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; valid_i = 1'b1;
    @(negedge clk);
    while (!ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || !ready_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic fast_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; f_valid_i = 1'b1;
    @(negedge clk);
    chk("fast_ready", 64'(f_ready_o), 64'd1);
    @(posedge clk);
    #1;
    f_valid_i = 1'b0;
    @(negedge clk);
    chk("fast_valid_1cyc", 64'(f_valid_o), 64'd1);
    chk("fast_result", 64'(f_result_o), 64'(model(op, a, b)));
    chk("fast_rd", 64'(f_rd_o), 64'(rd));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r_hold;
    logic [4:0]  d_hold;
    int          n;
    int          vcount;

    fork
      monitor();
      ready_drv();
    join_none

    // Pin the model with hand-computed values
    chk("model_mul",    64'(model(3'd0, 32'd7, 32'hFFFF_FFFD)), 64'hFFFF_FFEB);
    chk("model_mulh",   64'(model(3'd1, 32'h8000_0000, 32'h8000_0000)), 64'h4000_0000);
    chk("model_mulhu",  64'(model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);
    chk("model_mulhsu", 64'(model(3'd2, 32'hFFFF_FFFF, 32'd2)), 64'hFFFF_FFFF);
    chk("model_div",    64'(model(3'd4, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);
    chk("model_rem",    64'(model(3'd6, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);
    chk("model_divu",   64'(model(3'd5, 32'd100, 32'd7)), 64'd14);
    chk("model_remu",   64'(model(3'd7, 32'd100, 32'd7)), 64'd2);
    chk("model_div0",   64'(model(3'd4, 32'd5, 32'd0)), 64'hFFFF_FFFF);
    chk("model_rem0",   64'(model(3'd6, 32'd5, 32'd0)), 64'd5);
    chk("model_divovf", 64'(model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF)), 64'h8000_0000);
    chk("model_removf", 64'(model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF)), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    rstn_i = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_rd", 64'(rd_o), 64'd0);
    @(posedge clk);
    #1;

    // Directed operations from the test plan
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    issue(3'd5, 32'd100, 32'd7, 5'd7);
    issue(3'd7, 32'd100, 32'd7, 5'd8);
    issue(3'd4, 32'd5, 32'd0, 5'd9);
    issue(3'd6, 32'd5, 32'd0, 5'd10);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    drain();

    // FAST_MUL instance
    fast_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd13);
    fast_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd14);
    fast_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15);
    fast_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd16);
    for (int i = 0; i < 8; i++) begin
      fast_op(3'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), 5'($urandom));
    end

    // Backpressure
    rdy_val = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 5'd21);
    n = 0;
    while (!valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 64'(valid_o), 64'd1);
    r_hold = result_o;
    d_hold = rd_o;
    repeat (10) begin
      @(negedge clk);
      chk("bp_result_stable", 64'(result_o), 64'(r_hold));
      chk("bp_rd_stable", 64'(rd_o), 64'(d_hold));
      chk("bp_ready_low", 64'(ready_o), 64'd0);
    end
    rdy_val = 1'b1;
    n = 0;
    while (valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ready_after", 64'(ready_o), 64'd1);
    @(posedge clk);
    #1;
    issue(3'd7, 32'd100, 32'd7, 5'd22);
    drain();

    // Flush in the fifth DIV cycle
    issue(3'd4, 32'd1000, 32'd3, 5'd23);
    repeat (4) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 64'(busy_o), 64'd0);
    chk("flush_idle_ready", 64'(ready_o), 64'd1);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    chk("flush_no_valid", 64'(vcount), 64'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a multiply
    issue(3'd0, 32'h1234, 32'h5678, 5'd25);
    repeat (10) @(posedge clk);
    #3;
    chk("mid_mul_busy", 64'(busy_o), 64'd1);
    rstn_i = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd1);
    chk("arst_result", 64'(result_o), 64'd0);
    chk("arst_rd", 64'(rd_o), 64'd0);
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with random result backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 5'($urandom));
    end
    drain();
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
